// File: rtl/vec_pkg.sv
// Shared definitions for the vector issue controller.
// Contents: instruction class encoding, stall-reason encoding and the
// bitwidth() helper used to size register indices, VL and the counter.
package vec_pkg;

   typedef enum logic [1:0] {
      CLS_ARITH = 2'd0,
      CLS_LOAD  = 2'd1,
      CLS_STORE = 2'd2,
      CLS_SETVL = 2'd3
   } vclass_e;

   typedef enum logic [1:0] {
      STALL_NONE   = 2'd0,
      STALL_HAZARD = 2'd1,
      STALL_BUSY   = 2'd2,
      STALL_DRAIN  = 2'd3
   } stall_reason_e;

   // Bits needed to index n items; never less than one.
   function automatic int bitwidth(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/vec_issue_ctrl_if.sv
// Bus bundle between the instruction FIFO head, the execution units and the
// vector issue controller.
// Modports:
//   master - FIFO/unit side: drives head, ready, writeback and store_done,
//            observes issue requests, stall, reason, busy and current VL.
//   slave  - controller side (vec_issue_ctrl).
interface vec_issue_ctrl_if #(
   parameter int NUM_REGS = 32,
   parameter int MVL      = 32
);
   import vec_pkg::*;

   localparam int RW  = bitwidth(NUM_REGS);
   localparam int VLW = bitwidth(MVL) + 1;

   logic           head_valid;
   logic [1:0]     head_class;
   logic [RW-1:0]  head_src1;
   logic [RW-1:0]  head_src2;
   logic [RW-1:0]  head_dst;
   logic           head_masked;
   logic [VLW-1:0] setvl_req;

   logic           stall_o;
   logic           alu_valid;
   logic           mem_valid;
   logic           alu_ready;
   logic           mem_ready;
   logic [VLW-1:0] issue_vl;

   logic           wb_alu_valid;
   logic           wb_mem_valid;
   logic [RW-1:0]  wb_alu_dst;
   logic [RW-1:0]  wb_mem_dst;
   logic           store_done;
   logic [1:0]     stall_reason_o;
   logic           busy_o;

   modport master (
      output head_valid, head_class, head_src1, head_src2, head_dst,
             head_masked, setvl_req, alu_ready, mem_ready,
             wb_alu_valid, wb_mem_valid, wb_alu_dst, wb_mem_dst, store_done,
      input  stall_o, alu_valid, mem_valid, issue_vl, stall_reason_o, busy_o
   );

   modport slave (
      input  head_valid, head_class, head_src1, head_src2, head_dst,
             head_masked, setvl_req, alu_ready, mem_ready,
             wb_alu_valid, wb_mem_valid, wb_alu_dst, wb_mem_dst, store_done,
      output stall_o, alu_valid, mem_valid, issue_vl, stall_reason_o, busy_o
   );

endinterface

// File: rtl/vec_scoreboard.sv
// Per-register busy scoreboard for the vector issue controller.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   set_en/set_idx        - mark destination busy on ARITH/LOAD issue
//   clr_a_*/clr_b_*       - ALU and memory writeback clears (same cycle ok)
//   cls, src1, src2, dst,
//   masked                - head operands to check
//   hazard                - head reads or writes a busy register
// The hazard query looks at the registered bits only, so a writeback in the
// current cycle cannot unblock the head until the following cycle.
module vec_scoreboard
   import vec_pkg::*;
#(
   parameter int NUM_REGS = 32,
   localparam int RW = bitwidth(NUM_REGS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          set_en,
   input  logic [RW-1:0] set_idx,
   input  logic          clr_a_en,
   input  logic [RW-1:0] clr_a_idx,
   input  logic          clr_b_en,
   input  logic [RW-1:0] clr_b_idx,
   input  vclass_e       cls,
   input  logic [RW-1:0] src1,
   input  logic [RW-1:0] src2,
   input  logic [RW-1:0] dst,
   input  logic          masked,
   output logic          hazard
);

   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] busy_next;

   // Clears first, set last: a set target is never busy (hazard blocks it),
   // and clearing a non-busy bit is harmless, so the order only matters
   // for robustness.
   always_comb begin
      busy_next = busy;
      if (clr_a_en) busy_next[clr_a_idx] = 1'b0;
      if (clr_b_en) busy_next[clr_b_idx] = 1'b0;
      if (set_en)   busy_next[set_idx]   = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) busy <= '0;
      else     busy <= busy_next;
   end

   // STORE reads dst as data, ARITH/LOAD must not overwrite a pending dst,
   // so dst is checked for every class that touches registers.
   always_comb begin
      hazard = 1'b0;
      if (cls != CLS_SETVL)
         hazard = busy[src1] | busy[src2] | busy[dst] | (masked & busy[0]);
   end

endmodule

// File: rtl/vec_issue_ctrl.sv
// Vector issue controller: issues the FIFO head to the ALU or memory unit
// once its operands are free, tracks outstanding operations and serialises
// SETVL behind all in-flight work.
// Ports:
//   clk, rst - clock, synchronous active-high reset
//   bus      - vec_issue_ctrl_if.slave (head, issue handshake, writeback,
//              stall/stall reason, busy, current VL)
//
// state    | meaning
// ST_RUN   | normal issue; SETVL taken only when nothing is outstanding
// ST_DRAIN | SETVL at head, waiting for outstanding count to reach zero
module vec_issue_ctrl
   import vec_pkg::*;
#(
   parameter int NUM_REGS = 32,
   parameter int MVL      = 32
) (
   input logic             clk,
   input logic             rst,
   vec_issue_ctrl_if.slave bus
);

   localparam int VLW = bitwidth(MVL) + 1;
   localparam int CW  = bitwidth(2 * NUM_REGS) + 1;
   localparam int CW1 = CW + 1;
   localparam logic [VLW-1:0] VL_MAX = VLW'(MVL);

   typedef enum logic {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_e;

   state_e         state;
   logic [CW-1:0]  outstanding;
   logic [VLW-1:0] vl;

   vclass_e        cls;
   logic           hazard;
   logic           cnt_zero;
   logic           alu_req;
   logic           mem_req;
   logic           alu_fire;
   logic           mem_fire;
   logic           setvl_fire;
   logic           consumed;
   logic           set_en;
   stall_reason_e  reason;
   logic [1:0]     dec;
   logic [CW1-1:0] cnt_plus;
   logic           underflow;
   logic [CW-1:0]  cnt_next;

   assign cls      = vclass_e'(bus.head_class);
   assign cnt_zero = (outstanding == '0);

   vec_scoreboard #(.NUM_REGS(NUM_REGS)) u_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .set_en    (set_en),
      .set_idx   (bus.head_dst),
      .clr_a_en  (bus.wb_alu_valid),
      .clr_a_idx (bus.wb_alu_dst),
      .clr_b_en  (bus.wb_mem_valid),
      .clr_b_idx (bus.wb_mem_dst),
      .cls       (cls),
      .src1      (bus.head_src1),
      .src2      (bus.head_src2),
      .dst       (bus.head_dst),
      .masked    (bus.head_masked),
      .hazard    (hazard)
   );

   // Everything visible is forced quiet while rst is high.
   always_comb begin
      alu_req    = !rst && bus.head_valid && (cls == CLS_ARITH) && !hazard
                   && (state == ST_RUN);
      mem_req    = !rst && bus.head_valid
                   && ((cls == CLS_LOAD) || (cls == CLS_STORE)) && !hazard
                   && (state == ST_RUN);
      alu_fire   = alu_req && bus.alu_ready;
      mem_fire   = mem_req && bus.mem_ready;
      setvl_fire = !rst && bus.head_valid && (cls == CLS_SETVL)
                   && (state == ST_RUN) && cnt_zero;
      consumed   = alu_fire || mem_fire || setvl_fire;
      set_en     = alu_fire || (mem_fire && (cls == CLS_LOAD));

      reason = STALL_NONE;
      if (!rst && bus.head_valid && !consumed) begin
         if ((state == ST_DRAIN) || (cls == CLS_SETVL)) reason = STALL_DRAIN;
         else if (hazard)                               reason = STALL_HAZARD;
         else                                           reason = STALL_BUSY;
      end
   end

   assign bus.alu_valid      = alu_req;
   assign bus.mem_valid      = mem_req;
   assign bus.stall_o        = !rst && bus.head_valid && !consumed;
   assign bus.stall_reason_o = reason;
   assign bus.busy_o         = !rst && !cnt_zero;
   assign bus.issue_vl       = rst ? VL_MAX : vl;

   // Up to three retirements against at most one issue per cycle.
   assign dec       = 2'(bus.wb_alu_valid) + 2'(bus.wb_mem_valid) + 2'(bus.store_done);
   assign cnt_plus  = {1'b0, outstanding} + CW1'(alu_fire || mem_fire);
   assign underflow = (CW1'(dec) > cnt_plus);
   assign cnt_next  = underflow ? '0 : CW'(cnt_plus - CW1'(dec));

   no_underflow: assert property (@(posedge clk) disable iff (rst) !underflow);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_RUN;
         outstanding <= '0;
         vl          <= VL_MAX;
      end else begin
         outstanding <= cnt_next;
         if (setvl_fire)
            vl <= (bus.setvl_req > VL_MAX) ? VL_MAX : bus.setvl_req;
         if (state == ST_RUN) begin
            if (bus.head_valid && (cls == CLS_SETVL) && !cnt_zero)
               state <= ST_DRAIN;
         end else begin
            if (cnt_zero)
               state <= ST_RUN;
         end
      end
   end

endmodule
